// File: rtl/int_div_unit_if.sv
// Handshake bundle for the iterative integer divider.
// master drives the op and grant; slave is the divider.
interface int_div_unit_if #(
  parameter int XLEN = 32,
  parameter int RD_W = 5
);
  logic            flush;
  logic            in_valid;
  logic            in_ready;
  logic [1:0]      op;
  logic [XLEN-1:0] dividend;
  logic [XLEN-1:0] divisor;
  logic [RD_W-1:0] rd_i;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] result;
  logic [RD_W-1:0] rd_o;
  logic            busy;

  modport master (
    output flush, in_valid, op, dividend,
    output divisor, rd_i, out_ready,
    input  in_ready, out_valid, result,
    input  rd_o, busy
  );

  modport slave (
    input  flush, in_valid, op, dividend,
    input  divisor, rd_i, out_ready,
    output in_ready, out_valid, result,
    output rd_o, busy
  );
endinterface

// File: rtl/int_div_unit.sv
// Radix-2 restoring divider for DIV/DIVU/REM/REMU, one op in flight.
// Optional macro DIV_EARLY_OUT_EN: finish at accept when |a| < |b|.
module int_div_unit #(
  parameter int XLEN = 32,
  parameter int RD_W = 5
) (
  input  logic          clk,
  input  logic          reset,
  int_div_unit_if.slave bus
);
  localparam int CW = $clog2(XLEN);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  state_t          state;
  logic [XLEN-1:0] rem;
  logic [XLEN-1:0] quo;
  logic [XLEN-1:0] dvs;
  logic [CW-1:0]   cnt;
  logic            q_neg;
  logic            r_neg;
  logic            is_rem;
  logic [XLEN-1:0] res_q;
  logic [RD_W-1:0] rd_q;
  logic            in_rdy_q;
  logic            out_vld_q;
  logic            busy_q;

  logic            sgn;
  logic            a_neg;
  logic            b_neg;
  logic [XLEN-1:0] a_abs;
  logic [XLEN-1:0] b_abs;
  logic            div_zero;
  logic            ovf;
  logic            early;
  logic            special;
  logic [XLEN-1:0] spec_res;
  logic            accept;

  logic [XLEN:0]   rem_sh;
  logic [XLEN:0]   rem_dif;
  logic            ge;
  logic [XLEN-1:0] rem_nx;
  logic [XLEN-1:0] quo_nx;
  logic [XLEN-1:0] q_fix;
  logic [XLEN-1:0] r_fix;
  logic [XLEN-1:0] fin_res;

  assign bus.in_ready  = in_rdy_q;
  assign bus.out_valid = out_vld_q;
  assign bus.result    = res_q;
  assign bus.rd_o      = rd_q;
  assign bus.busy      = busy_q;

  assign accept = bus.in_valid && in_rdy_q
               && !bus.flush;

  // Operand magnitudes and the cases that skip iteration.
  always_comb begin
    sgn      = !bus.op[0];
    a_neg    = sgn && bus.dividend[XLEN-1];
    b_neg    = sgn && bus.divisor[XLEN-1];
    a_abs    = a_neg ? -bus.dividend
                     : bus.dividend;
    b_abs    = b_neg ? -bus.divisor
                     : bus.divisor;
    div_zero = (bus.divisor == '0);
    ovf      = sgn
      && (bus.dividend == {1'b1, {(XLEN-1){1'b0}}})
      && (bus.divisor == '1);
`ifdef DIV_EARLY_OUT_EN
    early    = !div_zero && (a_abs < b_abs);
`else
    early    = 1'b0;
`endif
    special  = div_zero || ovf || early;
    spec_res = '0;
    unique case (1'b1)
      div_zero:
        spec_res = bus.op[1] ? bus.dividend : '1;
      ovf:
        spec_res = bus.op[1] ? '0 : bus.dividend;
      early:
        spec_res = bus.op[1] ? bus.dividend : '0;
      default:
        spec_res = '0;
    endcase
  end

  // One restoring step; borrow of the wide subtract decides the bit.
  always_comb begin
    rem_sh  = {rem, quo[XLEN-1]};
    rem_dif = rem_sh - {1'b0, dvs};
    ge      = !rem_dif[XLEN];
    rem_nx  = ge ? rem_dif[XLEN-1:0]
                 : rem_sh[XLEN-1:0];
    quo_nx  = {quo[XLEN-2:0], ge};
    q_fix   = q_neg ? -quo_nx : quo_nx;
    r_fix   = r_neg ? -rem_nx : rem_nx;
    fin_res = is_rem ? r_fix : q_fix;
  end

  // Control FSM with registered handshake outputs and datapath.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      rem       <= '0;
      quo       <= '0;
      dvs       <= '0;
      cnt       <= '0;
      q_neg     <= 1'b0;
      r_neg     <= 1'b0;
      is_rem    <= 1'b0;
      res_q     <= '0;
      rd_q      <= '0;
      in_rdy_q  <= 1'b1;
      out_vld_q <= 1'b0;
      busy_q    <= 1'b0;
    end else if (bus.flush) begin
      state     <= IDLE;
      in_rdy_q  <= 1'b1;
      out_vld_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (accept) begin
            rd_q     <= bus.rd_i;
            is_rem   <= bus.op[1];
            q_neg    <= a_neg ^ b_neg;
            r_neg    <= a_neg;
            rem      <= '0;
            quo      <= a_abs;
            dvs      <= b_abs;
            cnt      <= CW'(XLEN-1);
            in_rdy_q <= 1'b0;
            busy_q   <= 1'b1;
            if (special) begin
              res_q     <= spec_res;
              state     <= DONE;
              out_vld_q <= 1'b1;
            end else begin
              state <= CALC;
            end
          end
        end
        CALC: begin
          rem <= rem_nx;
          quo <= quo_nx;
          cnt <= cnt - 1'b1;
          if (cnt == '0) begin
            res_q     <= fin_res;
            state     <= DONE;
            out_vld_q <= 1'b1;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            state     <= IDLE;
            out_vld_q <= 1'b0;
            in_rdy_q  <= 1'b1;
            busy_q    <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_int_div_unit.sv
// Bench for int_div_unit: directed literal cases plus random
// traffic checked every cycle against an arithmetic model.
module tb_int_div_unit;
  localparam int XLEN = 32;
  localparam int RD_W = 5;
`ifdef DIV_EARLY_OUT_EN
  localparam int EL = 1;
`else
  localparam int EL = 33;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  int_div_unit_if #(.XLEN(XLEN), .RD_W(RD_W)) bus ();

  int_div_unit #(.XLEN(XLEN), .RD_W(RD_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm,
                     input logic [63:0] got,
                     input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%h want=%h t=%0t",
               nm, got, want, $time);
    end
  endtask

  function automatic logic [31:0] ref_res(
      input logic [1:0] op,
      input logic [31:0] a,
      input logic [31:0] b);
    int sa;
    int sb;
    if (b == 0) return op[1] ? a : 32'hFFFF_FFFF;
    if (!op[0] && a == 32'h8000_0000
        && b == 32'hFFFF_FFFF)
      return op[1] ? 32'h0 : 32'h8000_0000;
    if (op[0]) return op[1] ? a % b : a / b;
    sa = $signed(a);
    sb = $signed(b);
    return op[1] ? sa % sb : sa / sb;
  endfunction

  function automatic longint mag(input logic s,
                                 input logic [31:0] v);
    longint x;
    x = s ? longint'($signed(v)) : longint'(v);
    return (x < 0) ? -x : x;
  endfunction

  function automatic bit is_fast(
      input logic [1:0] op,
      input logic [31:0] a,
      input logic [31:0] b);
    if (b == 0) return 1'b1;
    if (!op[0] && a == 32'h8000_0000
        && b == 32'hFFFF_FFFF) return 1'b1;
`ifdef DIV_EARLY_OUT_EN
    if (mag(!op[0], a) < mag(!op[0], b)) return 1'b1;
`endif
    return 1'b0;
  endfunction

  // Model: 0 idle, 1 iterating, 2 result pending.
  int          m_state = 0;
  int          m_left  = 0;
  bit          m_live  = 1'b0;
  logic [31:0] m_res   = '0;
  logic [4:0]  m_rd    = '0;
  int          n_done  = 0;

  always @(posedge clk) begin
    if (reset) begin
      m_state = 0;
      m_res   = '0;
      m_rd    = '0;
      m_live  = 1'b1;
    end else if (bus.flush) begin
      m_state = 0;
    end else begin
      case (m_state)
        0: if (bus.in_valid) begin
          m_res = ref_res(bus.op, bus.dividend,
                          bus.divisor);
          m_rd  = bus.rd_i;
          m_left = XLEN;
          m_state = is_fast(bus.op, bus.dividend,
                            bus.divisor) ? 2 : 1;
        end
        1: begin
          m_left--;
          if (m_left == 0) m_state = 2;
        end
        default: if (bus.out_ready) begin
          m_state = 0;
          n_done++;
        end
      endcase
    end
  end

  // Compare DUT against model every cycle.
  always @(negedge clk) begin
    if (m_live && !reset) begin
      chk("out_valid", 64'(bus.out_valid),
          64'(m_state == 2));
      chk("in_ready", 64'(bus.in_ready),
          64'(m_state == 0));
      chk("busy", 64'(bus.busy), 64'(m_state != 0));
      if (m_state == 2) begin
        chk("result", 64'(bus.result), 64'(m_res));
        chk("rd_o", 64'(bus.rd_o), 64'(m_rd));
      end
    end
  end

  task automatic run_op(input string nm,
                        input logic [1:0] op,
                        input logic [31:0] a,
                        input logic [31:0] b,
                        input logic [4:0] rd,
                        input logic [31:0] exp,
                        input int exp_lat,
                        input int hold);
    int w;
    int lat;
    w = 0;
    while (!bus.in_ready && w < 100) begin
      @(posedge clk); #1; w++;
    end
    chk({nm, " idle"}, 64'(bus.in_ready), 64'd1);
    bus.in_valid  = 1'b1;
    bus.op        = op;
    bus.dividend  = a;
    bus.divisor   = b;
    bus.rd_i      = rd;
    bus.out_ready = 1'b0;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    lat = 1;
    while (!bus.out_valid && lat < 60) begin
      @(posedge clk); #1; lat++;
    end
    chk({nm, " lat"}, 64'(lat), 64'(exp_lat));
    chk({nm, " res"}, 64'(bus.result), 64'(exp));
    chk({nm, " rd"}, 64'(bus.rd_o), 64'(rd));
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      chk({nm, " hold res"}, 64'(bus.result),
          64'(exp));
      chk({nm, " hold rd"}, 64'(bus.rd_o), 64'(rd));
      chk({nm, " hold rdy"}, 64'(bus.in_ready), 64'd0);
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    chk({nm, " drop"}, 64'(bus.out_valid), 64'd0);
    chk({nm, " back"}, 64'(bus.in_ready), 64'd1);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'($urandom_range(0, 20));
      4: return -32'($urandom_range(1, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int saw;
    bus.flush     = 1'b0;
    bus.in_valid  = 1'b0;
    bus.op        = 2'b00;
    bus.dividend  = '0;
    bus.divisor   = '0;
    bus.rd_i      = '0;
    bus.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    chk("rst in_ready", 64'(bus.in_ready), 64'd1);
    chk("rst out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst busy", 64'(bus.busy), 64'd0);
    chk("rst result", 64'(bus.result), 64'd0);
    chk("rst rd_o", 64'(bus.rd_o), 64'd0);

    chk("model div", 64'(ref_res(2'b00, 32'd100, 32'd7)),
        64'd14);
    chk("model rem", 64'(ref_res(2'b10, -32'd100,
        32'd7)), 64'hFFFF_FFFE);

    run_op("div 100/7", 2'b00, 32'd100, 32'd7, 5'd5,
           32'd14, 33, 0);
    run_op("rem 100/7", 2'b10, 32'd100, 32'd7, 5'd6,
           32'd2, 33, 0);
    run_op("div -100/7", 2'b00, -32'd100, 32'd7, 5'd7,
           32'hFFFF_FFF2, 33, 0);
    run_op("rem -100/7", 2'b10, -32'd100, 32'd7, 5'd8,
           32'hFFFF_FFFE, 33, 0);
    run_op("rem 100/-7", 2'b10, 32'd100, -32'd7, 5'd9,
           32'd2, 33, 0);
    run_op("divu ff/2", 2'b01, 32'hFFFF_FFFF, 32'd2,
           5'd10, 32'h7FFF_FFFF, 33, 0);
    run_op("remu ff/2", 2'b11, 32'hFFFF_FFFF, 32'd2,
           5'd11, 32'd1, 33, 0);
    run_op("div -1/2", 2'b00, 32'hFFFF_FFFF, 32'd2,
           5'd12, 32'd0, EL, 0);
    run_op("div x/0", 2'b00, 32'd77, 32'd0, 5'd13,
           32'hFFFF_FFFF, 1, 0);
    run_op("remu 1234/0", 2'b11, 32'h1234, 32'd0, 5'd14,
           32'h1234, 1, 0);
    run_op("div ovf", 2'b00, 32'h8000_0000,
           32'hFFFF_FFFF, 5'd15, 32'h8000_0000, 1, 0);
    run_op("rem ovf", 2'b10, 32'h8000_0000,
           32'hFFFF_FFFF, 5'd16, 32'd0, 1, 0);
    run_op("divu hold", 2'b01, 32'd1000, 32'd10, 5'd17,
           32'd100, 33, 10);

    bus.in_valid = 1'b1;
    bus.op       = 2'b00;
    bus.dividend = 32'd100;
    bus.divisor  = 32'd7;
    bus.rd_i     = 5'd3;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    bus.flush    = 1'b1;
    bus.in_valid = 1'b1;
    bus.dividend = 32'd50;
    bus.divisor  = 32'd0;
    @(posedge clk); #1;
    bus.flush    = 1'b0;
    bus.in_valid = 1'b0;
    chk("flush ready", 64'(bus.in_ready), 64'd1);
    chk("flush busy", 64'(bus.busy), 64'd0);
    saw = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (bus.out_valid) saw = 1;
    end
    chk("flush no out", 64'(saw), 64'd0);
    run_op("div 9/3", 2'b00, 32'd9, 32'd3, 5'd18,
           32'd3, 33, 0);
    run_op("div 3/9", 2'b00, 32'd3, 32'd9, 5'd19,
           32'd0, EL, 0);
    run_op("rem -3/9", 2'b10, -32'd3, 32'd9, 5'd20,
           32'hFFFF_FFFD, EL, 0);

    bus.in_valid = 1'b1;
    bus.dividend = 32'd500;
    bus.divisor  = 32'd3;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("midrst result", 64'(bus.result), 64'd0);
    chk("midrst rd_o", 64'(bus.rd_o), 64'd0);
    chk("midrst ready", 64'(bus.in_ready), 64'd1);

    for (int c = 0; c < 6000; c++) begin
      @(posedge clk); #1;
      bus.in_valid  = ($urandom_range(0, 3) != 0);
      bus.op        = 2'($urandom_range(0, 3));
      bus.dividend  = pick();
      bus.divisor   = pick();
      bus.rd_i      = 5'($urandom);
      bus.out_ready = ($urandom_range(0, 2) != 0);
      bus.flush     = ($urandom_range(0, 99) == 0);
    end
    @(posedge clk); #1;
    bus.in_valid  = 1'b0;
    bus.flush     = 1'b0;
    bus.out_ready = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    chk("random completions", 64'(n_done > 50), 64'd1);
    chk("end idle", 64'(bus.in_ready), 64'd1);

    $display("test done: total=%0d bad=%0d",
             total, bad);
    $finish;
  end
endmodule
